// File: rtl/serial_fsm_sched.sv
// Round-robin scheduler that time-shares one serial FSM among N bit-stream requesters.
// Each grant clears the FSM, streams BURST bits into it and counts its 1 outputs.
module serial_fsm_sched #(
  parameter int N     = 4,
  parameter int BURST = 8,
  parameter int HW    = $clog2(BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         bit_in,
  input  logic                 y_in,
  output logic                 x_out,
  output logic                 fsm_rstn,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 done,
  output logic [HW-1:0]        hits
);

  localparam int OW = $clog2(N);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic            fsm_rstn_q, fsm_rstn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [HW-1:0]   hits_q, hits_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            found_s;
  logic [OW-1:0]   pick_s;
  logic [OW-1:0]   idx_s;
  logic            last_s;

  assign last_s = (cnt_q == CW'(BURST - 1));

  // Round-robin pick: first set request at or above the pointer, wrapping modulo N.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      if ((int'(ptr_q) + i) >= N) begin
        idx_s = OW'(int'(ptr_q) + i - N);
      end else begin
        idx_s = OW'(int'(ptr_q) + i);
      end
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // State and output registers; reset puts the shared FSM in reset as well.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      fsm_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hits_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      fsm_rstn_q <= fsm_rstn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hits_q     <= hits_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered-output next values; done is a pulse, everything else holds by default.
  always_comb begin
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    fsm_rstn_d = fsm_rstn_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hits_d     = hits_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        fsm_rstn_d = 1'b1;
        if (found_s) begin
          owner_d    = pick_s;
          gnt_d      = {{(N-1){1'b0}}, 1'b1} << pick_s;
          fsm_rstn_d = 1'b0;
          hits_d     = '0;
          busy_d     = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_CLEAR: begin
        fsm_rstn_d = 1'b1;
        cnt_d      = '0;
      end
      S_RUN: begin
        hits_d = hits_q + HW'(y_in);
        if (last_s) begin
          cnt_d  = '0;
          gnt_d  = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (owner_q == OW'(N - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = owner_q + OW'(1);
        end
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  // The owner's bit stream reaches the shared FSM only while bits are being counted.
  assign x_out    = (state_q == S_RUN) ? bit_in[owner_q] : 1'b0;
  assign fsm_rstn = fsm_rstn_q;
  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hits     = hits_q;

endmodule

// File: tb/tb_serial_fsm_sched.sv
// Directed bench for serial_fsm_sched: N=4/BURST=8 instance plus an N=2/BURST=1 instance,
// each with an echo stub (y_in = x_out) standing in for the shared FSM.
module tb_serial_fsm_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] bit_in = 4'b0000;
  logic       x_out, fsm_rstn, busy, done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic [3:0] hits;

  logic [1:0] req1 = 2'b00;
  logic [1:0] bit1 = 2'b00;
  logic       x1, fsm_rstn1, busy1, done1;
  logic [1:0] gnt1;
  logic [0:0] owner1;
  logic [0:0] hits1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_fsm_sched #(.N(4), .BURST(8)) u_dut (
    .clk(clk), .rstn(rstn), .req(req), .bit_in(bit_in), .y_in(x_out),
    .x_out(x_out), .fsm_rstn(fsm_rstn), .gnt(gnt), .owner(owner),
    .busy(busy), .done(done), .hits(hits)
  );

  serial_fsm_sched #(.N(2), .BURST(1)) u_b1 (
    .clk(clk), .rstn(rstn), .req(req1), .bit_in(bit1), .y_in(x1),
    .x_out(x1), .fsm_rstn(fsm_rstn1), .gnt(gnt1), .owner(owner1),
    .busy(busy1), .done(done1), .hits(hits1)
  );

  // Runs one grant from IDLE (called at a negedge) and reports what was observed.
  task automatic drive_burst(input logic [3:0] rq, input logic [7:0] bits,
                             input logic [3:0] rq_run, input int drop_after,
                             output int own, output int hits_o, output int gnt_cyc,
                             output int frst_low, output logic done_ok,
                             output time t_done, output int xerr);
    logic [3:0] oh;
    bit got;
    own = -1; hits_o = -1; gnt_cyc = 0; frst_low = 0; done_ok = 1'b0; t_done = 0; xerr = 0;
    req = rq;
    bit_in = 4'b0000;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk); @(negedge clk);
      if (busy) got = 1'b1;
    end
    if (!got) return;
    own = int'(owner);
    oh = 4'b0001 << owner;
    if (gnt === oh) gnt_cyc++;
    if (fsm_rstn === 1'b0) frst_low++;
    if (x_out !== 1'b0) xerr++;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k == drop_after) req = rq_run;
      bit_in[owner] = bits[k];
      #1;
      if (x_out !== bits[k]) xerr++;
      if (gnt === oh) gnt_cyc++;
      if (fsm_rstn === 1'b0) frst_low++;
      @(posedge clk); @(negedge clk);
    end
    bit_in = 4'b0000;
    done_ok = (done === 1'b1) && (gnt === 4'b0000) && (busy === 1'b0);
    hits_o = int'(hits);
    t_done = $time;
    if (x_out !== 1'b0) xerr++;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({gnt, owner, fsm_rstn, busy, done, hits, x_out} !== 15'd0) begin
      errors++; $display("FAIL reset_vals got %h exp 0", {gnt, owner, fsm_rstn, busy, done, hits, x_out});
    end
    @(negedge clk); #2; rstn = 1'b1;
    @(negedge clk);
    checks++; if (fsm_rstn !== 1'b1) begin errors++; $display("FAIL reset_fsm_rstn got %b exp 1", fsm_rstn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_single();
    int own, h, gc, fl, xe; logic dok; time td;
    drive_burst(4'b0001, 8'b1100_1101, 4'b0000, 0, own, h, gc, fl, dok, td, xe);
    checks++; if (own !== 0) begin errors++; $display("FAIL single_owner got %0d exp 0", own); end
    checks++; if (gc !== 9) begin errors++; $display("FAIL single_gnt_cycles got %0d exp 9", gc); end
    checks++; if (fl !== 1) begin errors++; $display("FAIL single_fsm_rstn_low got %0d exp 1", fl); end
    checks++; if (!dok) begin errors++; $display("FAIL single_done got %b exp 1", dok); end
    checks++; if (h !== 5) begin errors++; $display("FAIL single_hits got %0d exp 5", h); end
    checks++; if (xe !== 0) begin errors++; $display("FAIL single_x_out errors got %0d exp 0", xe); end
    @(posedge clk); @(negedge clk);
    checks++; if ({done, busy, fsm_rstn, hits} !== {1'b0, 1'b0, 1'b1, 4'd5}) begin
      errors++; $display("FAIL single_idle got %b%b%b/%0d exp 001/5", done, busy, fsm_rstn, hits);
    end
  endtask

  task automatic test_all_requesting();
    int own, h, gc, fl, xe; logic dok; time td, tprev;
    logic [7:0] pat [4];
    int exp_h [4];
    pat[0] = 8'hFF; pat[1] = 8'h00; pat[2] = 8'h0F; pat[3] = 8'hA5;
    exp_h[0] = 8; exp_h[1] = 0; exp_h[2] = 4; exp_h[3] = 4;
    @(negedge clk); rstn = 1'b0; #2; rstn = 1'b1;
    @(negedge clk);
    tprev = 0;
    for (int g = 0; g < 4; g++) begin
      drive_burst(4'b1111, pat[g], 4'b1111, 8, own, h, gc, fl, dok, td, xe);
      checks++; if (own !== g) begin errors++; $display("FAIL all_owner got %0d exp %0d", own, g); end
      checks++; if (gc !== 9 || !dok || h !== exp_h[g] || xe !== 0) begin
        errors++; $display("FAIL all_grant%0d gnt %0d done %b hits %0d xerr %0d exp 9 1 %0d 0", g, gc, dok, h, xe, exp_h[g]);
      end
      if (g > 0) begin
        checks++; if (td - tprev !== 110) begin errors++; $display("FAIL all_spacing got %0t exp 110", td - tprev); end
      end
      tprev = td;
    end
  endtask

  task automatic test_wrap();
    int own, h, gc, fl, xe; logic dok; time td;
    drive_burst(4'b0100, 8'h01, 4'b0100, 8, own, h, gc, fl, dok, td, xe);
    checks++; if (own !== 2) begin errors++; $display("FAIL wrap_first got %0d exp 2", own); end
    drive_burst(4'b0011, 8'h03, 4'b0011, 8, own, h, gc, fl, dok, td, xe);
    checks++; if (own !== 0 || h !== 2) begin errors++; $display("FAIL wrap_second owner %0d hits %0d exp 0 2", own, h); end
    drive_burst(4'b0011, 8'h80, 4'b0011, 8, own, h, gc, fl, dok, td, xe);
    checks++; if (own !== 1 || h !== 1) begin errors++; $display("FAIL wrap_third owner %0d hits %0d exp 1 1", own, h); end
  endtask

  task automatic test_req_drop();
    int own, h, gc, fl, xe; logic dok; time td;
    drive_burst(4'b0100, 8'hFF, 4'b0000, 3, own, h, gc, fl, dok, td, xe);
    checks++; if (own !== 2) begin errors++; $display("FAIL drop_owner got %0d exp 2", own); end
    checks++; if (!dok || h !== 8 || gc !== 9) begin
      errors++; $display("FAIL drop_burst done %b hits %0d gnt %0d exp 1 8 9", dok, h, gc);
    end
  endtask

  task automatic test_async_reset();
    int own, h, gc, fl, xe, dcnt; logic dok; time td;
    bit got;
    req = 4'b1000;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk); @(negedge clk);
      if (busy) got = 1'b1;
    end
    checks++; if (!got || owner !== 2'd3) begin errors++; $display("FAIL areset_grant busy %b owner %0d exp 1 3", got, owner); end
    req = 4'b0000;
    bit_in = 4'b1111;
    for (int k = 0; k < 4; k++) begin @(posedge clk); @(negedge clk); end
    #2; rstn = 1'b0; #1;
    checks++; if ({gnt, owner, fsm_rstn, busy, done, hits, x_out} !== 15'd0) begin
      errors++; $display("FAIL areset_vals got %h exp 0", {gnt, owner, fsm_rstn, busy, done, hits, x_out});
    end
    #1; rstn = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin @(negedge clk); if (done !== 1'b0) dcnt++; end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL areset_no_done got %0d exp 0", dcnt); end
    bit_in = 4'b0000;
    drive_burst(4'b1111, 8'h11, 4'b0000, 0, own, h, gc, fl, dok, td, xe);
    checks++; if (own !== 0 || h !== 2) begin errors++; $display("FAIL areset_next owner %0d hits %0d exp 0 2", own, h); end
  endtask

  task automatic test_burst1();
    @(negedge clk);
    req1 = 2'b01; bit1 = 2'b11;
    @(posedge clk); @(negedge clk);
    checks++; if ({busy1, gnt1, fsm_rstn1, x1} !== 5'b1_01_0_0) begin
      errors++; $display("FAIL b1_clear got %b%b%b%b exp 10100", busy1, gnt1, fsm_rstn1, x1);
    end
    req1 = 2'b00;
    @(posedge clk); @(negedge clk);
    checks++; if ({x1, fsm_rstn1} !== 2'b11) begin errors++; $display("FAIL b1_run got %b%b exp 11", x1, fsm_rstn1); end
    @(posedge clk); @(negedge clk);
    checks++; if ({done1, hits1, gnt1, busy1, x1} !== 6'b1_1_00_0_0) begin
      errors++; $display("FAIL b1_done got %b%b%b%b%b exp 110000", done1, hits1, gnt1, busy1, x1);
    end
    @(posedge clk); @(negedge clk);
    checks++; if ({done1, hits1, x1} !== 3'b010) begin errors++; $display("FAIL b1_idle got %b%b%b exp 010", done1, hits1, x1); end
    bit1 = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_requesting();
    test_wrap();
    test_req_drop();
    test_async_reset();
    test_burst1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
